refill_return_buffer: RTL and testbench

//  Collects AXI read-data beats of a cache-line refill into a line register for the cache data-RAM write.

---
 rtl/refill_return_buffer_pkg.sv | 19 +
 rtl/refill_return_buffer_if.sv | 30 +++
 rtl/refill_return_buffer_fetch_window_sel.sv | 33 +++
 rtl/refill_return_buffer.sv | 109 ++++++++++
 tb/tb_refill_return_buffer.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/refill_return_buffer_pkg.sv
// refill_return_buffer_pkg: shared defaults, FSM state codes and the fetch-window slot rule
package refill_return_buffer_pkg;
  localparam int DEF_WORD_W = 32;
  localparam int DEF_LINE_WORDS = 4;
  localparam int DEF_FETCH_WORDS = 2;
  typedef logic [1:0] state_t;
  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_FILL = 2'd1;
  localparam state_t S_DRAIN = 2'd2;
  localparam state_t S_DONE = 2'd3;
  // Beat counter needs headroom past one line so over-long bursts can be detected
  function automatic int cnt_w(input int line_words);
    return $clog2(line_words) + 2;
  endfunction
  // Line slot feeding window word j; -1 means the word lies beyond the line
  function automatic int win_slot(input int off, input int j, input logic unc, input int line_words);
    return unc ? j : (off + j < line_words ? off + j : -1);
  endfunction
endpackage

// File: rtl/refill_return_buffer_if.sv
// refill_return_buffer_if: refill request, AXI R channel and cache-side outputs of the refill buffer
interface refill_return_buffer_if import refill_return_buffer_pkg::*; #(
  parameter int WORD_W = DEF_WORD_W,
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  parameter int FETCH_WORDS = DEF_FETCH_WORDS
);
  localparam int OFF_W = $clog2(LINE_WORDS);
  logic i_start;
  logic i_uncache;
  logic [OFF_W-1:0] i_offset;
  logic i_flush;
  logic i_rvalid;
  logic i_rlast;
  logic [WORD_W-1:0] i_rdata;
  logic o_rready;
  logic o_busy;
  logic [LINE_WORDS*WORD_W-1:0] o_line_data;
  logic o_line_valid;
  logic [FETCH_WORDS*WORD_W-1:0] o_fetch_data;
  logic o_fetch_valid;
  logic o_err;
  modport master (
    output i_start, i_uncache, i_offset, i_flush, i_rvalid, i_rlast, i_rdata,
    input o_rready, o_busy, o_line_data, o_line_valid, o_fetch_data, o_fetch_valid, o_err
  );
  modport slave (
    input i_start, i_uncache, i_offset, i_flush, i_rvalid, i_rlast, i_rdata,
    output o_rready, o_busy, o_line_data, o_line_valid, o_fetch_data, o_fetch_valid, o_err
  );
endinterface

// File: rtl/refill_return_buffer_fetch_window_sel.sv
// fetch_window_sel: extracts the fetch window from a line and reports whether all its words are present
module fetch_window_sel import refill_return_buffer_pkg::*; #(
  parameter int WORD_W = DEF_WORD_W,
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  parameter int FETCH_WORDS = DEF_FETCH_WORDS
)(
  input  logic [LINE_WORDS*WORD_W-1:0]  line_i,
  input  logic [LINE_WORDS-1:0]         vld_i,
  input  logic [$clog2(LINE_WORDS)-1:0] off_i,
  input  logic                          unc_i,
  output logic [FETCH_WORDS*WORD_W-1:0] win_o,
  output logic                          complete_o
);
  localparam int OFF_W = $clog2(LINE_WORDS);
  logic [WORD_W-1:0] words [LINE_WORDS];
  // View the flat line as addressable words
  always_comb
    for (int k = 0; k < LINE_WORDS; k++) words[k] = line_i[k*WORD_W +: WORD_W];
  // Words past the end of the line read as zero and never hold the window back
  always_comb begin
    int s;
    s = 0;
    win_o = '0;
    complete_o = 1'b1;
    for (int j = 0; j < FETCH_WORDS; j++) begin
      s = win_slot(int'(off_i), j, unc_i, LINE_WORDS);
      if (s >= 0) begin
        win_o[j*WORD_W +: WORD_W] = words[OFF_W'(s)];
        complete_o = complete_o & vld_i[OFF_W'(s)];
      end
    end
  end
endmodule

// File: rtl/refill_return_buffer.sv
// refill_return_buffer: assembles AXI refill beats into a cache line with early-restart fetch window
module refill_return_buffer import refill_return_buffer_pkg::*; #(
  parameter int WORD_W = DEF_WORD_W,
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  parameter int FETCH_WORDS = DEF_FETCH_WORDS
)(
  input logic clk,
  input logic rstn,
  refill_return_buffer_if.slave bus
);
  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int CNT_W = cnt_w(LINE_WORDS);
  localparam int CW1 = CNT_W + 1;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0] beat_n, exp_n;
  logic [LINE_WORDS-1:0] vld_q, vld_d;
  logic [LINE_WORDS*WORD_W-1:0] line_q, line_d;
  logic [FETCH_WORDS*WORD_W-1:0] fd_q, win_d;
  logic [OFF_W-1:0] off_q, off_d;
  logic unc_q, unc_d, err_q, err_d, fv_q, fv_d;
  logic busy, beat, start_ok, complete_d;

  assign busy = state_q == S_FILL || state_q == S_DRAIN;
  assign beat = bus.i_rvalid && busy;
  assign start_ok = bus.i_start && !busy;
  assign beat_n = {1'b0, cnt_q} + 1'b1;
  assign exp_n = unc_q ? CW1'(FETCH_WORDS) : CW1'(LINE_WORDS);

  // Refill bookkeeping: open on start, capture beats in arrival order, check burst length
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    vld_d = vld_q;
    line_d = line_q;
    unc_d = unc_q;
    off_d = off_q;
    err_d = err_q;
    if (start_ok) begin
      state_d = S_FILL;
      unc_d = bus.i_uncache;
      off_d = bus.i_offset;
      cnt_d = '0;
      vld_d = '0;
    end else if (state_q == S_DONE) state_d = S_IDLE;
    else if (state_q == S_FILL && bus.i_flush) state_d = S_DRAIN;
    if (beat) begin
      cnt_d = &cnt_q ? cnt_q : cnt_q + 1'b1;
      err_d = err_q | (bus.i_rlast ? beat_n < exp_n : beat_n > exp_n);
      if (bus.i_rlast) state_d = state_q == S_FILL && !unc_q && !bus.i_flush ? S_DONE : S_IDLE;
      for (int k = 0; k < LINE_WORDS; k++)
        if (state_q == S_FILL && cnt_q == CNT_W'(k)) begin
          line_d[k*WORD_W +: WORD_W] = bus.i_rdata;
          vld_d[k] = 1'b1;
        end
    end
  end

  fetch_window_sel #(
    .WORD_W(WORD_W),
    .LINE_WORDS(LINE_WORDS),
    .FETCH_WORDS(FETCH_WORDS)
  ) u_sel (
    .line_i(line_d),
    .vld_i(vld_d),
    .off_i(off_d),
    .unc_i(unc_d),
    .win_o(win_d),
    .complete_o(complete_d)
  );

  // Window-ready flag latches once the window fills and drops on a new refill, a flush or a drain
  always_comb
    fv_d = start_ok || bus.i_flush || state_d == S_DRAIN ? 1'b0 : fv_q || (state_q == S_FILL && complete_d);

  // State registers; reset empties the buffer and returns to idle
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      vld_q <= '0;
      line_q <= '0;
      fd_q <= '0;
      off_q <= '0;
      unc_q <= 1'b0;
      err_q <= 1'b0;
      fv_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      vld_q <= vld_d;
      line_q <= line_d;
      fd_q <= win_d;
      off_q <= off_d;
      unc_q <= unc_d;
      err_q <= err_d;
      fv_q <= fv_d;
    end

  assign bus.o_rready = 1'b1;
  assign bus.o_busy = busy;
  assign bus.o_line_data = line_q;
  assign bus.o_line_valid = state_q == S_DONE;
  assign bus.o_fetch_data = fd_q;
  assign bus.o_fetch_valid = fv_q;
  assign bus.o_err = err_q;

  assert property (@(posedge clk) disable iff (!rstn) !(bus.i_start && busy));
endmodule

// File: tb/tb_refill_return_buffer.sv
// tb_refill_return_buffer: randomized refill traffic checked by a scoreboard against a line/window model
module tb_refill_return_buffer;
  import refill_return_buffer_pkg::*;
  localparam int W = DEF_WORD_W;
  localparam int LW = DEF_LINE_WORDS;
  localparam int FW = DEF_FETCH_WORDS;
  localparam int OW = $clog2(LW);

  typedef struct {logic [FW*W-1:0] d; int cyc;} fexp_t;
  typedef struct {logic [LW*W-1:0] d; int cyc;} lexp_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  refill_return_buffer_if bus ();
  refill_return_buffer dut (.clk(clk), .rstn(rstn), .bus(bus));

  fexp_t fq[$];
  lexp_t lq[$];
  logic [W-1:0] ml [LW];
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit err_m = 1'b0;
  logic fv_prev = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [LW*W-1:0] act, input logic [LW*W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [FW*W-1:0] win_m(input bit unc, input int off);
    logic [FW*W-1:0] r;
    r = '0;
    for (int j = 0; j < FW; j++)
      if (unc) r[j*W +: W] = ml[j];
      else if (off + j < LW) r[j*W +: W] = ml[off + j];
    return r;
  endfunction

  function automatic logic [LW*W-1:0] line_m();
    logic [LW*W-1:0] r;
    for (int k = 0; k < LW; k++) r[k*W +: W] = ml[k];
    return r;
  endfunction

  // Monitor: every fetch_valid rise and every line_valid pulse must match the next expectation
  always @(negedge clk) begin
    fexp_t fe;
    lexp_t le;
    if (!rstn) fv_prev <= 1'b0;
    else begin
      if (bus.o_fetch_valid && !fv_prev) begin
        if (fq.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL fetch_unexpected: fetch_valid rose at cycle %0d with nothing expected", cyc);
        end else begin
          fe = fq.pop_front();
          chk("fetch_data", bus.o_fetch_data, fe.d);
          chk("fetch_cycle", cyc, fe.cyc);
        end
      end
      if (bus.o_line_valid) begin
        if (lq.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL line_unexpected: line_valid at cycle %0d with nothing expected", cyc);
        end else begin
          le = lq.pop_front();
          chk("line_data", bus.o_line_data, le.d);
          chk("line_cycle", cyc, le.cyc);
        end
      end
      fv_prev <= bus.o_fetch_valid;
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_line_data"}, bus.o_line_data, '0);
    chk({tag, "_fetch_data"}, bus.o_fetch_data, '0);
    chk({tag, "_line_valid"}, bus.o_line_valid, 0);
    chk({tag, "_fetch_valid"}, bus.o_fetch_valid, 0);
    chk({tag, "_err"}, bus.o_err, 0);
    chk({tag, "_busy"}, bus.o_busy, 0);
    chk({tag, "_rready"}, bus.o_rready, 1);
  endtask

  // One refill: start, nb beats with random gaps, optional flush before beat fl
  task automatic refill(input bit unc, input int off, input int nb, input int fl, input int gapmax);
    int expn, wc;
    bit flushed;
    logic [W-1:0] d;
    expn = unc ? FW : LW;
    wc = unc ? FW - 1 : ((off + FW < LW ? off + FW : LW) - 1);
    flushed = 1'b0;
    bus.i_start = 1'b1;
    bus.i_uncache = unc;
    bus.i_offset = OW'(off);
    tick();
    bus.i_start = 1'b0;
    bus.i_uncache = 1'b0;
    for (int b = 0; b < nb; b++) begin
      if (b == fl) begin
        bus.i_flush = 1'b1;
        tick();
        bus.i_flush = 1'b0;
        flushed = 1'b1;
        chk("drain_fetch_valid", bus.o_fetch_valid, 0);
        chk("drain_busy", bus.o_busy, 1);
        chk("drain_rready", bus.o_rready, 1);
      end
      repeat ($urandom_range(0, gapmax)) tick();
      d = $urandom;
      bus.i_rvalid = 1'b1;
      bus.i_rlast = b == nb - 1;
      bus.i_rdata = d;
      if (!flushed && b < LW) ml[b] = d;
      tick();
      bus.i_rvalid = 1'b0;
      bus.i_rlast = 1'b0;
      if (!flushed && b == wc) fq.push_back('{win_m(unc, off), cyc});
      if (!flushed && !unc && b == nb - 1) lq.push_back('{line_m(), cyc});
    end
    if (nb < expn || nb > expn + 1) err_m = 1'b1;
    chk("busy_after_rlast", bus.o_busy, 0);
    chk("err", bus.o_err, err_m);
  endtask

  initial begin
    int unc, off, nb, fl, expn, k, r;
    bus.i_start = 1'b0;
    bus.i_uncache = 1'b0;
    bus.i_offset = '0;
    bus.i_flush = 1'b0;
    bus.i_rvalid = 1'b0;
    bus.i_rlast = 1'b0;
    bus.i_rdata = '0;
    for (int i = 0; i < LW; i++) ml[i] = '0;
    repeat (3) tick();
    check_reset_outputs("reset");
    rstn = 1'b1;
    tick();
    refill(0, 0, 4, -1, 0);
    refill(0, 3, 4, -1, 3);
    tick();
    refill(1, 2, 2, -1, 1);
    refill(0, 1, 4, 2, 1);
    tick();
    refill(0, 0, 3, -1, 0);
    refill(0, 2, 4, -1, 0);
    tick();
    bus.i_start = 1'b1;
    bus.i_offset = OW'(1);
    tick();
    bus.i_start = 1'b0;
    bus.i_rvalid = 1'b1;
    bus.i_rdata = $urandom;
    tick();
    bus.i_rvalid = 1'b0;
    #2 rstn = 1'b0;
    #1 check_reset_outputs("async_reset");
    for (int i = 0; i < LW; i++) ml[i] = '0;
    err_m = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    tick();
    refill(0, 1, 4, -1, 1);
    repeat (80) begin
      unc = $urandom_range(0, 1);
      off = $urandom_range(0, LW - 1);
      expn = unc ? FW : LW;
      r = $urandom_range(0, 9);
      nb = expn;
      fl = -1;
      if (r == 0) begin
        k = $urandom_range(1, expn);
        nb = k == expn ? expn + 2 : k;
      end else if (r < 3) fl = $urandom_range(0, expn - 1);
      refill(unc[0], off, nb, fl, 2);
      repeat ($urandom_range(0, 2)) tick();
    end
    repeat (3) tick();
    chk("fetch_queue_empty", fq.size(), 0);
    chk("line_queue_empty", lq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
